// File: rtl/ex_stage_mc_pkg.sv
// ex_pkg: shared constants for the execute stage (ALU opcodes, forwarding
// selects, multiplier FSM states) plus a small opcode helper.
package ex_pkg;

  // ALU operation codes (13..15 reserved: result 0, single-cycle)
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_MULHU = 4'd12;

  // Forwarding selects; 2'b11 falls back to the register file like FWD_RF
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Iterative multiplier FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/ex_stage_mc_if.sv
// ex_stage_mc_if: ID/EX-side inputs and EX/MEM-side outputs of the execute
// stage. master = surrounding pipeline, slave = execute stage.
interface ex_stage_mc_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] ext;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic [1:0]      fa;
  logic [1:0]      fb;
  logic [XLEN-1:0] exmem_res;
  logic [XLEN-1:0] memwb_res;
  logic            stall;
  logic            out_valid;
  logic [XLEN-1:0] alu_res;
  logic            zero;
  logic [XLEN-1:0] store_data;

  modport master (
    output flush, in_valid, rd1, rd2, ext, alu_src, alu_op, fa, fb,
           exmem_res, memwb_res,
    input  stall, out_valid, alu_res, zero, store_data
  );

  modport slave (
    input  flush, in_valid, rd1, rd2, ext, alu_src, alu_op, fa, fb,
           exmem_res, memwb_res,
    output stall, out_valid, alu_res, zero, store_data
  );
endinterface

// File: rtl/ex_stage_mc_mul.sv
// ex_mul_iter: radix-2 shift-add unsigned multiplier, one partial-product
// step per cycle for XLEN cycles. o_prod is the product including the
// current cycle's step, so the caller can register the final value on the
// edge that closes the last BUSY cycle.
module ex_mul_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic              o_busy,
  output logic              o_last,
  output logic [2*XLEN-1:0] o_prod
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  logic [0:0]        r_state;
  logic [SHW-1:0]    r_cnt;
  logic [XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0] r_prod;   // {partial high, remaining multiplier bits}
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod_step;

  // One step: add multiplicand to the high half if the current multiplier
  // LSB is set, then shift the whole register (with carry) right by one
  always_comb begin
    w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]}
                + (r_prod[0] ? {1'b0, r_mcand} : {(XLEN+1){1'b0}});
    w_prod_step = {w_sum, r_prod[XLEN-1:1]};
  end

  // FSM, step counter and datapath registers; abort discards the partial product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mcand <= i_a;
            r_prod  <= {{XLEN{1'b0}}, i_b};
            r_cnt   <= '0;
            r_state <= ST_BUSY;
          end
        end
        default: begin
          r_prod <= w_prod_step;
          r_cnt  <= r_cnt + SHW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = (r_state == ST_BUSY);
  assign o_last = o_busy && (r_cnt == CNT_LAST);
  assign o_prod = w_prod_step;

endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: MIPS execute stage - forwarding muxes, single-cycle ALU,
// optional iterative multiplier (build with EX_MUL_EN defined) and the
// registered EX/MEM result. Without EX_MUL_EN, MUL/MULHU act as reserved
// ops and stall is tied low.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_stage_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b_fwd;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu;
  logic [SHW-1:0]  w_shamt;
  logic            w_is_mul;
  logic            w_mul_busy;
  logic            w_mul_last;
  logic [XLEN-1:0] w_mul_res;

  logic            r_out_valid;
  logic            r_zero;
  logic [XLEN-1:0] r_alu_res;
  logic [XLEN-1:0] r_store_data;

  // Operand forwarding; select 2'b11 behaves like the register-file path
  always_comb begin
    case (bus.fa)
      FWD_EXMEM: w_a = bus.exmem_res;
      FWD_MEMWB: w_a = bus.memwb_res;
      default:   w_a = bus.rd1;
    endcase
    case (bus.fb)
      FWD_EXMEM: w_b_fwd = bus.exmem_res;
      FWD_MEMWB: w_b_fwd = bus.memwb_res;
      default:   w_b_fwd = bus.rd2;
    endcase
    w_b     = bus.alu_src ? bus.ext : w_b_fwd;
    w_shamt = w_b[SHW-1:0];
  end

  // Single-cycle ALU; multiply codes are produced by the multiplier path only
  always_comb begin
    case (bus.alu_op)
      OP_ADD:   w_alu = w_a + w_b;
      OP_SUB:   w_alu = w_a - w_b;
      OP_AND:   w_alu = w_a & w_b;
      OP_OR:    w_alu = w_a | w_b;
      OP_XOR:   w_alu = w_a ^ w_b;
      OP_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      OP_SLL:   w_alu = w_a << w_shamt;
      OP_SRL:   w_alu = w_a >> w_shamt;
      OP_SRA:   w_alu = $unsigned($signed(w_a) >>> w_shamt);
      OP_PASSB: w_alu = w_b;
      default:  w_alu = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic              w_issue;
  logic              r_mul_hi;
  logic [2*XLEN-1:0] w_product;

  assign w_is_mul = is_mul_op(bus.alu_op);
  assign w_issue  = !w_mul_busy && bus.in_valid && w_is_mul && !bus.flush;

  ex_mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_issue),
    .i_abort (bus.flush),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_busy  (w_mul_busy),
    .o_last  (w_mul_last),
    .o_prod  (w_product)
  );

  // Remember which product half the in-flight multiply must return
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_hi <= 1'b0;
    end else if (w_issue) begin
      r_mul_hi <= (bus.alu_op == OP_MULHU);
    end
  end

  assign w_mul_res = r_mul_hi ? w_product[2*XLEN-1:XLEN] : w_product[XLEN-1:0];
  // Stall drops in the last BUSY cycle so upstream advances with the result
  assign bus.stall = w_issue || (w_mul_busy && !w_mul_last && !bus.flush);
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_last = 1'b0;
  assign w_mul_res  = '0;
  assign bus.stall  = 1'b0;
`endif

  // EX/MEM result register: flush kills, multiply completion or ALU writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_alu_res    <= '0;
      r_zero       <= 1'b1;
      r_store_data <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_mul_busy) begin
      r_out_valid <= w_mul_last;
      if (w_mul_last) begin
        r_alu_res <= w_mul_res;
        r_zero    <= (w_mul_res == '0);
      end
    end else if (bus.in_valid && !w_is_mul) begin
      r_out_valid  <= 1'b1;
      r_alu_res    <= w_alu;
      r_zero       <= (w_alu == '0);
      r_store_data <= w_b_fwd;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.alu_res    = r_alu_res;
  assign bus.zero       = r_zero;
  assign bus.store_data = r_store_data;

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage for the 5-stage pipelined MIPS core: operand forwarding muxes, extended single-cycle ALU, optional iterative multiplier, and a registered EX/MEM result register. Sits between the ID/EX and EX/MEM boundaries. Issues a stall to the upstream stages while a multi-cycle multiply is in flight and emits a bubble (out_valid=0) to MEM until the multiply completes.

## Interface
- XLEN, 32, datapath width; must be a power of two ≥ 8
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of the current EX instruction
- in_valid  in  1  ID/EX holds a valid instruction
- rd1, rd2  in  XLEN  register-file operands
- ext  in  XLEN  sign-/zero-extended immediate
- alu_src  in  1  1: B operand = ext; 0: B operand = forwarded rd2
- alu_op  in  4  operation code (see Operation)
- fa, fb  in  2  forwarding selects for A / B
- exmem_res, memwb_res  in  XLEN  forwarded results from EX/MEM and MEM/WB
- stall  out  1  combinational; upstream holds its registers when 1
- out_valid  out  1  registered; EX/MEM entry is valid
- alu_res  out  XLEN  registered result
- zero  out  1  registered; alu_res == 0
- store_data  out  XLEN  registered forwarded rd2 (B before the alu_src mux)

## Operation
- Forwarding: 00 → rd, 10 → exmem_res, 01 → memwb_res, 11 → rd (same as 00). Every case assigns; no latches.
- alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB, 11 MUL (low XLEN of the unsigned product), 12 MULHU (high XLEN). 13–15 reserved: result 0, single-cycle.
- Shifts use B[SHW-1:0]. ADD/SUB wrap modulo 2^XLEN with no overflow flag. SLT/SLTU produce 0 or 1, zero-extended.
- FSM states: IDLE, BUSY.
  - IDLE with in_valid and a single-cycle op: register the result; out_valid←1 at the next edge.
  - IDLE with in_valid and MUL/MULHU: latch the post-forwarding A and B; cnt←0; go to BUSY; out_valid←0.
  - IDLE with in_valid=0: out_valid←0; alu_res, zero and store_data hold.
  - BUSY: one radix-2 shift-add step per cycle; cnt increments each cycle; forwarding inputs and rd1/rd2 are ignored.
  - BUSY with cnt == XLEN-1: final step; write the selected product half to alu_res; out_valid←1; go to IDLE.
- stall = (IDLE & in_valid & is_mul & !flush) | (BUSY & cnt != XLEN-1). Stall drops in the final BUSY cycle so upstream advances on the same edge the result is written.
- flush (priority below rst): out_valid←0 and state←IDLE, aborting any BUSY. alu_res and store_data hold. stall=0 while flush is high.
- rst: state IDLE, cnt 0, out_valid 0, alu_res 0, zero 1, store_data 0, multiplier registers 0.

## Timing
- Single-cycle ops: 1-cycle latency, throughput 1 per cycle, stall stays 0.
- MUL/MULHU: instruction occupies XLEN+1 cycles (entry + XLEN BUSY); stall high for XLEN cycles. Result and out_valid appear at the edge closing the last BUSY cycle.
- Back-to-back MUL: the next MUL is accepted in IDLE on the cycle after completion. No overlap.
- Reset or flush mid-multiply: takes effect at that edge; the partial product is discarded and no valid result is emitted.

## Configuration
- EX_MUL_EN defined: multiplier, BUSY state, cnt and stall logic are present as specified.
- EX_MUL_EN undefined: ops 11/12 behave as reserved (result 0, single-cycle). stall is tied 0. No FSM or multiplier registers are built.

## Structure
- Package ex_pkg: alu_op localparams/enum, forwarding select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB), FSM state enum.
- Sub-module ex_mul_iter holds the iterative multiplier: start, operands, busy/done, 2·XLEN product. It is instantiated only under EX_MUL_EN. ALU and forwarding muxes stay in the top module.

## Test plan
- ADD with fa=10, exmem_res=0x0000_0005, rd2=0x3, alu_src=0 → alu_res=8, out_valid=1 one cycle later, stall=0.
- SRA, A=0x8000_0000, ext=4, alu_src=1 → alu_res=0xF800_0000. SLT with A=-1, B=1 → 1; SLTU with the same operands → 0.
- MUL 0xFFFF_FFFF×2 (EX_MUL_EN) → stall high for 32 cycles, out_valid low throughout, then alu_res=0xFFFF_FFFE with out_valid=1. MULHU with the same operands → 1.
- flush asserted in BUSY cycle 10 → stall and out_valid=0 next cycle, state IDLE; a following ADD completes normally.
- rst asserted mid-MUL → all outputs return to reset values at the next edge (zero=1).
- fa=11, fb=11 with rd1=7, rd2=9, SUB → alu_res=0xFFFF_FFFE and store_data=9.
